// File: rtl/seq_pkg.sv
// Shared phase encoding for the step sequencer, interval timer and VGA screen mux.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [3:0] STEP_IDLE   = 4'b0001;
  localparam logic [3:0] STEP_SHOW   = 4'b0010;
  localparam logic [3:0] STEP_PAUSE  = 4'b0100;
  localparam logic [3:0] STEP_FINISH = 4'b1000;

  function automatic logic [3:0] step_code(input state_t s);
    case (s)
      ST_IDLE:   return STEP_IDLE;
      ST_SHOW:   return STEP_SHOW;
      ST_PAUSE:  return STEP_PAUSE;
      ST_FINISH: return STEP_FINISH;
      default:   return STEP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer and rising-edge detector for a raw pushbutton.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync_p0, sync_p1, prev_p2;
  logic vld_p0, vld_p1;
  logic armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      // A button held through reset must be seen released before it can fire.
      armed   <= armed | (vld_p1 & ~sync_p1);
    end
  end

  assign pulse = armed & sync_p1 & ~prev_p2;

endmodule

// File: rtl/step_sequencer.sv
// Run sequencer: alternates SHOW and PAUSE for ROUNDS intervals with a SHOW watchdog.
module step_sequencer
  import seq_pkg::*;
#(
  parameter int ROUNDS      = 4,
  parameter int PAUSE_CYC   = 25_000_000,
  parameter int TIMEOUT_CYC = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       abort,
  input  logic       done,
  output logic [3:0] step,
  output logic [1:0] screen_sel,
  output logic [3:0] round_cnt,
  output logic       busy,
  output logic       err
);

  localparam int MAX_CYC = (PAUSE_CYC > TIMEOUT_CYC) ? PAUSE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       ROUNDS_MAX = 4'(ROUNDS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       round_nxt;
  logic             err_nxt;
  logic             start_evt;

  function automatic logic [3:0] sat_inc(input logic [3:0] r);
    return (r >= ROUNDS_MAX) ? ROUNDS_MAX : r + 4'd1;
  endfunction

  btn_sync u_btn_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (start_btn),
    .pulse (start_evt)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    round_nxt = round_cnt;
    err_nxt   = err;
    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      round_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt = '0;
          if (start_evt) begin
            state_nxt = ST_SHOW;
            round_nxt = '0;
            err_nxt   = 1'b0;
          end
        end
        ST_SHOW: begin
          // done takes priority over a watchdog expiring in the same cycle
          if (done) begin
            round_nxt = sat_inc(round_cnt);
            cnt_nxt   = '0;
            state_nxt = (sat_inc(round_cnt) == ROUNDS_MAX) ? ST_FINISH : ST_PAUSE;
          end else if (cnt == TMO_LAST) begin
            state_nxt = ST_FINISH;
            cnt_nxt   = '0;
            err_nxt   = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (cnt == PAUSE_LAST) begin
            state_nxt = ST_SHOW;
            cnt_nxt   = '0;
          end
        end
        ST_FINISH: begin
          cnt_nxt = '0;
          if (start_evt) state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      round_cnt  <= '0;
      err        <= 1'b0;
      step       <= STEP_IDLE;
      screen_sel <= 2'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      round_cnt  <= round_nxt;
      err        <= err_nxt;
      step       <= step_code(state_nxt);
      screen_sel <= 2'(state_nxt);
      busy       <= (state_nxt == ST_SHOW) || (state_nxt == ST_PAUSE);
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Scenario bench for step_sequencer with ROUNDS=2, PAUSE_CYC=3, TIMEOUT_CYC=10.
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0;
  logic       abort = 1'b0;
  logic       done = 1'b0;
  logic [3:0] step;
  logic [1:0] screen_sel;
  logic [3:0] round_cnt;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] step;
    logic [3:0] rnd;
    logic       err;
    logic       busy;
    logic [1:0] scr;
    int         dwell;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       me;
  logic [3:0] prev_step = 4'b0001;
  int         dwell = 0;

  step_sequencer #(.ROUNDS(2), .PAUSE_CYC(3), .TIMEOUT_CYC(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .abort      (abort),
    .done       (done),
    .step       (step),
    .screen_sel (screen_sel),
    .round_cnt  (round_cnt),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic [3:0] r, input logic e,
                      input logic b, input logic [1:0] sc, input int d);
    exp_t x;
    x.step = s; x.rnd = r; x.err = e; x.busy = b; x.scr = sc; x.dwell = d;
    exp_q.push_back(x);
  endtask

  task automatic press();
    start_btn = 1'b1;
    cycle(4);
    start_btn = 1'b0;
    cycle(2);
  endtask

  // Every phase change is matched against the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      prev_step = step;
      dwell = 0;
    end else begin
      dwell++;
      if (step !== prev_step) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transition: step %b -> %b, none queued", prev_step, step);
        end else begin
          me = exp_q.pop_front();
          if (step !== me.step || round_cnt !== me.rnd || err !== me.err ||
              busy !== me.busy || screen_sel !== me.scr ||
              (me.dwell >= 0 && dwell != me.dwell)) begin
            errors++;
            $display("FAIL transition: got step %b rnd %0d err %b busy %b scr %0d dwell %0d; expected step %b rnd %0d err %b busy %b scr %0d dwell %0d",
                     step, round_cnt, err, busy, screen_sel, dwell,
                     me.step, me.rnd, me.err, me.busy, me.scr, me.dwell);
          end
        end
        prev_step = step;
        dwell = 0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    cycle(3);
    checks++;
    if ({step, screen_sel, round_cnt, busy, err} !== {4'b0001, 2'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got step %b scr %0d rnd %0d busy %b err %b; expected 0001 0 0 0 0",
               step, screen_sel, round_cnt, busy, err);
    end
    rst = 1'b1;
    cycle(5);
    checks++;
    if (step !== 4'b0001) begin
      errors++;
      $display("FAIL idle_after_release: got step %b, expected 0001", step);
    end
  endtask

  task automatic test_start();
    int n;
    n = 0;
    push(4'b0010, 4'd0, 1'b0, 1'b1, 2'd1, -1);
    start_btn = 1'b1;
    for (int i = 0; i < 4 && step !== 4'b0010; i++) begin
      cycle(1);
      n++;
    end
    checks++;
    if (step !== 4'b0010 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: got step %b busy %b after %0d cycles, expected 0010 1 within 4", step, busy, n);
    end
    cycle(5 - n);
    start_btn = 1'b0;
  endtask

  task automatic test_full_run();
    push(4'b0100, 4'd1, 1'b0, 1'b1, 2'd2, -1);
    push(4'b0010, 4'd1, 1'b0, 1'b1, 2'd1, 3);
    push(4'b1000, 4'd2, 1'b0, 1'b0, 2'd3, -1);
    done = 1'b1;
    cycle(1);
    done = 1'b0;
    checks++;
    if (step !== 4'b0100 || round_cnt !== 4'd1) begin
      errors++;
      $display("FAIL run_first_done: got step %b rnd %0d, expected 0100 1", step, round_cnt);
    end
    cycle(3);
    checks++;
    if (step !== 4'b0010) begin
      errors++;
      $display("FAIL run_pause_end: got step %b, expected 0010", step);
    end
    cycle(2);
    done = 1'b1;
    cycle(1);
    done = 1'b0;
    checks++;
    if ({step, round_cnt, err, busy} !== {4'b1000, 4'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL run_finish: got step %b rnd %0d err %b busy %b, expected 1000 2 0 0",
               step, round_cnt, err, busy);
    end
    push(4'b0001, 4'd2, 1'b0, 1'b0, 2'd0, -1);
    press();
    checks++;
    if (step !== 4'b0001 || round_cnt !== 4'd2) begin
      errors++;
      $display("FAIL finish_to_idle: got step %b rnd %0d, expected 0001 2", step, round_cnt);
    end
  endtask

  task automatic test_timeout();
    push(4'b0010, 4'd0, 1'b0, 1'b1, 2'd1, -1);
    push(4'b1000, 4'd0, 1'b1, 1'b0, 2'd3, 10);
    press();
    cycle(8);
    checks++;
    if ({step, err, round_cnt} !== {4'b1000, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL timeout_finish: got step %b err %b rnd %0d, expected 1000 1 0", step, err, round_cnt);
    end
    push(4'b0001, 4'd0, 1'b1, 1'b0, 2'd0, -1);
    press();
    checks++;
    if (step !== 4'b0001 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err_sticky: got step %b err %b, expected 0001 1", step, err);
    end
    push(4'b0010, 4'd0, 1'b0, 1'b1, 2'd1, -1);
    press();
    checks++;
    if (step !== 4'b0010 || err !== 1'b0) begin
      errors++;
      $display("FAIL restart_clears_err: got step %b err %b, expected 0010 0", step, err);
    end
    push(4'b0001, 4'd0, 1'b0, 1'b0, 2'd0, -1);
    abort = 1'b1;
    cycle(1);
    abort = 1'b0;
  endtask

  task automatic test_done_last_cycle();
    push(4'b0010, 4'd0, 1'b0, 1'b1, 2'd1, -1);
    push(4'b0100, 4'd1, 1'b0, 1'b1, 2'd2, 10);
    start_btn = 1'b1;
    cycle(4);
    start_btn = 1'b0;
    cycle(8);
    done = 1'b1;
    cycle(1);
    done = 1'b0;
    checks++;
    if ({step, err, round_cnt} !== {4'b0100, 1'b0, 4'd1}) begin
      errors++;
      $display("FAIL done_beats_timeout: got step %b err %b rnd %0d, expected 0100 0 1", step, err, round_cnt);
    end
  endtask

  task automatic test_abort();
    done = 1'b1;
    cycle(1);
    done = 1'b0;
    checks++;
    if (step !== 4'b0100 || round_cnt !== 4'd1) begin
      errors++;
      $display("FAIL done_in_pause: got step %b rnd %0d, expected 0100 1", step, round_cnt);
    end
    push(4'b0001, 4'd0, 1'b0, 1'b0, 2'd0, -1);
    abort = 1'b1;
    done = 1'b1;
    cycle(1);
    abort = 1'b0;
    done = 1'b0;
    checks++;
    if (step !== 4'b0001 || round_cnt !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_with_done: got step %b rnd %0d busy %b, expected 0001 0 0", step, round_cnt, busy);
    end
    done = 1'b1;
    cycle(1);
    done = 1'b0;
    cycle(1);
    checks++;
    if (step !== 4'b0001 || round_cnt !== 4'd0) begin
      errors++;
      $display("FAIL done_in_idle: got step %b rnd %0d, expected 0001 0", step, round_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    push(4'b0010, 4'd0, 1'b0, 1'b1, 2'd1, -1);
    start_btn = 1'b1;
    cycle(4);
    rst = 1'b0;
    #1;
    checks++;
    if ({step, screen_sel, round_cnt, busy, err} !== {4'b0001, 2'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_show: got step %b scr %0d rnd %0d busy %b err %b; expected 0001 0 0 0 0",
               step, screen_sel, round_cnt, busy, err);
    end
    cycle(2);
    rst = 1'b1;
    cycle(8);
    checks++;
    if (step !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_button_after_reset: got step %b busy %b, expected 0001 0", step, busy);
    end
    start_btn = 1'b0;
    cycle(3);
    push(4'b0010, 4'd0, 1'b0, 1'b1, 2'd1, -1);
    press();
    checks++;
    if (step !== 4'b0010) begin
      errors++;
      $display("FAIL repress_after_reset: got step %b, expected 0010", step);
    end
    push(4'b0001, 4'd0, 1'b0, 1'b0, 2'd0, -1);
    abort = 1'b1;
    cycle(1);
    abort = 1'b0;
    cycle(2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_start();
    test_full_run();
    test_timeout();
    test_done_last_cycle();
    test_abort();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_transitions: got %0d still queued, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter ROUNDS, default 4: number of timed intervals per run (2..15).
REQ-002 Parameter PAUSE_CYC, default 25_000_000: clk cycles spent in PAUSE.
REQ-003 Parameter TIMEOUT_CYC, default 200_000_000: max clk cycles in SHOW without done.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start_btn  in  1  raw, asynchronous pushbutton; run start/acknowledge.
REQ-007 abort  in  1  synchronous, level-sampled abort request.
REQ-008 done  in  1  one-cycle interval-complete pulse from the downstream interval timer.
REQ-009 step  out  4  one-hot phase code driven to the interval timer.
REQ-010 screen_sel  out  2  VGA screen index: 0 idle, 1 show, 2 pause, 3 finish.
REQ-011 round_cnt  out  4  completed intervals in current run.
REQ-012 busy  out  1  high in SHOW or PAUSE.
REQ-013 err  out  1  sticky timeout flag; set when the run ended by watchdog.

Function
REQ-014 Four states: IDLE (step 0001), SHOW (step 0010), PAUSE (step 0100), FINISH (step 1000).
REQ-015 step, screen_sel, busy SHALL be registered and change on the same edge as the state register.
REQ-016 start_btn SHALL pass a 2-flop synchronizer; only a rising edge of the synchronized signal is an event (3-cycle pad-to-event latency max).
REQ-017 IDLE: start event -> SHOW, round_cnt <= 0, err <= 0.
REQ-018 SHOW: watchdog counter increments each cycle from 0 on entry; done -> round_cnt+1.
REQ-019 SHOW on done: if round_cnt+1 == ROUNDS -> FINISH, else -> PAUSE.
REQ-020 SHOW: watchdog reaching TIMEOUT_CYC-1 without done -> FINISH, err <= 1, round_cnt unchanged.
REQ-021 done and timeout in same cycle: done wins, err stays 0.
REQ-022 PAUSE: counter from 0 on entry; reaching PAUSE_CYC-1 -> SHOW with watchdog cleared.
REQ-023 done outside SHOW SHALL be ignored; start events outside IDLE/FINISH SHALL be ignored.
REQ-024 FINISH: start event -> IDLE; round_cnt and err hold until then.
REQ-025 abort high in any state -> IDLE next edge, round_cnt <= 0, counters cleared; abort overrides done, timeout and start.
REQ-026 Shared cycle counter width = $clog2(max(PAUSE_CYC, TIMEOUT_CYC)); SHALL never wrap (cleared on every state entry).
REQ-027 round_cnt SHALL saturate at ROUNDS; never wraps.

Reset
REQ-028 rst low: state IDLE, step 0001, screen_sel 0, round_cnt 0, busy 0, err 0, counters 0, synchronizer flops 0.
REQ-029 Reset mid-run SHALL abandon the run immediately; no start event generated on release even if start_btn held high.
REQ-030 Reset deassertion synchronised externally; block SHALL NOT produce an event in the first cycle after release.

Structure
REQ-031 Package seq_pkg SHALL hold the state enum and the four STEP_* 4-bit codes, shared with the interval timer and VGA screen mux.
REQ-032 One sub-module btn_sync: 2-flop synchronizer plus rising-edge detector, output one-cycle pulse.
REQ-033 Single FSM always_ff plus next-state always_comb; no latches, no derived clocks.

Verification (ROUNDS=2, PAUSE_CYC=3, TIMEOUT_CYC=10)
REQ-034 Reset then start_btn high 5 cycles -> exactly one SHOW entry, step 0010 within 4 cycles, busy 1.
REQ-035 Full run: done pulse, wait, done pulse -> PAUSE lasts 3 cycles, round_cnt 1 then 2, final step 1000, err 0, busy 0.
REQ-036 No done in SHOW -> FINISH at cycle 10 after entry, err 1, round_cnt 0; start -> IDLE, next start clears err.
REQ-037 done asserted in the 10th SHOW cycle -> PAUSE, err 0, round_cnt 1.
REQ-038 abort during PAUSE with done coincident -> IDLE, step 0001, round_cnt 0; done pulses in IDLE/PAUSE leave round_cnt unchanged.
REQ-039 rst low mid-SHOW with start_btn held -> all outputs at reset values; after release no SHOW entry until button released and re-pressed.
